processor_datapath: RTL and testbench

8-bit datapath of the enhanced single-accumulator processor. It holds the instruction register (IR), the 5-bit program counter (PC), a 32×8 RAM, and the accumulator A with its add/subtract unit. It executes the register transfers requested each cycle by the external control FSM, and returns opcode and status flags to that FSM.

---
 rtl/datapath_pkg.sv | 12 +
 rtl/processor_datapath_ram.sv | 19 +
 rtl/processor_datapath.sv | 84 ++++++++
 tb/tb_processor_datapath.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared constants and select encodings for the accumulator datapath.
package datapath_pkg;
  localparam int DW = 8;
  localparam int AW = 5;

  typedef enum logic [1:0] {
    ASEL_ALU  = 2'b00,
    ASEL_IN   = 2'b01,
    ASEL_RAM  = 2'b10,
    ASEL_ZERO = 2'b11
  } asel_e;
endpackage

// File: rtl/processor_datapath_ram.sv
// 32x8 RAM: combinational read, write on the rising clock edge.
module ram32x8
  import datapath_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [2**AW];

  // Synchronous write; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];
endmodule

// File: rtl/processor_datapath.sv
// Accumulator datapath: IR, PC, A, ALU and RAM driven by external control.
module processor_datapath
  import datapath_pkg::*;
(
  input  logic          clk,
  input  logic          clear,
  input  logic          IRload,
  input  logic          JMPmux,
  input  logic          PCload,
  input  logic          Meminst,
  input  logic          MemWr,
  input  logic [1:0]    Asel,
  input  logic          Aload,
  input  logic          Sub,
  input  logic [DW-1:0] in,
  output logic [DW-1:0] out,
  output logic [2:0]    IR75,
  output logic          Aeq0,
  output logic          Apos,
  output logic [AW-1:0] MeminstOut,
  output logic [DW-1:0] regAOut,
  output logic [DW-1:0] RAMout,
  output logic [AW-1:0] IR40
);
  logic [DW-1:0] ir_q, ir_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] a_q,  a_d;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] ram_rd;
  logic [DW-1:0] alu;
  logic          ram_we;

  // Address mux, ALU and next-state selection for IR, PC and A.
  always_comb begin
    mem_addr = Meminst ? ir_q[AW-1:0] : pc_q;
    alu      = Sub ? (a_q - ram_rd) : (a_q + ram_rd);
    ir_d     = IRload ? ram_rd : ir_q;
    pc_d     = pc_q;
    if (PCload) pc_d = JMPmux ? ir_q[AW-1:0] : (pc_q + 5'd1);
    a_d = a_q;
    if (Aload) begin
      case (asel_e'(Asel))
        ASEL_ALU:  a_d = alu;
        ASEL_IN:   a_d = in;
        ASEL_RAM:  a_d = ram_rd;
        ASEL_ZERO: a_d = '0;
        default:   a_d = a_q;
      endcase
    end
  end

  // A write coinciding with clear must not reach the RAM.
  assign ram_we = MemWr & clear;

  ram32x8 u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (mem_addr),
    .wdata (a_q),
    .rdata (ram_rd)
  );

  // Architectural registers; clear is asynchronous and dominates all loads.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      ir_q <= '0;
      pc_q <= '0;
      a_q  <= '0;
    end else begin
      ir_q <= ir_d;
      pc_q <= pc_d;
      a_q  <= a_d;
    end
  end

  assign out        = a_q;
  assign regAOut    = a_q;
  assign IR75       = ir_q[7:5];
  assign IR40       = ir_q[4:0];
  assign Aeq0       = (a_q == '0);
  assign Apos       = ~a_q[DW-1];
  assign MeminstOut = mem_addr;
  assign RAMout     = ram_rd;
endmodule

// File: tb/tb_processor_datapath.sv
// Randomized bench for processor_datapath with a behavioural reference model.
module tb_processor_datapath;
  logic       clk = 0;
  logic       clear;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub;
  logic [1:0] Asel;
  logic [7:0] in;
  logic [7:0] out, regAOut, RAMout;
  logic [2:0] IR75;
  logic [4:0] MeminstOut, IR40;
  logic       Aeq0, Apos;

  processor_datapath dut (
    .clk(clk), .clear(clear), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
    .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload), .Sub(Sub),
    .in(in), .out(out), .IR75(IR75), .Aeq0(Aeq0), .Apos(Apos),
    .MeminstOut(MeminstOut), .regAOut(regAOut), .RAMout(RAMout), .IR40(IR40)
  );

  always #5 clk = ~clk;

  // Reference model state: plain integers and an array for memory.
  int   m_ir, m_pc, m_a;
  int   m_mem  [32];
  bit   m_memv [32];
  int   errors = 0;
  int   checks = 0;
  bit   run = 0;

  function automatic int m_addr();
    return Meminst ? (m_ir % 32) : m_pc;
  endfunction

  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      m_ir <= 0; m_pc <= 0; m_a <= 0;
    end else begin
      int ad, rd, nxt;
      ad  = m_addr();
      rd  = m_mem[ad];
      if (IRload) m_ir <= rd;
      if (PCload) m_pc <= JMPmux ? (m_ir % 32) : ((m_pc + 1) % 32);
      if (Aload) begin
        case (Asel)
          2'd0: nxt = Sub ? (m_a - rd + 256) % 256 : (m_a + rd) % 256;
          2'd1: nxt = int'(in);
          2'd2: nxt = rd;
          default: nxt = 0;
        endcase
        m_a <= nxt;
      end
      if (MemWr) begin
        m_mem[ad]  <= m_a;
        m_memv[ad] <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (run) begin
      int ad;
      ad = m_addr();
      chk("out",        int'(out),        m_a);
      chk("regAOut",    int'(regAOut),    m_a);
      chk("IR75",       int'(IR75),       m_ir / 32);
      chk("IR40",       int'(IR40),       m_ir % 32);
      chk("Aeq0",       int'(Aeq0),       (m_a == 0) ? 1 : 0);
      chk("Apos",       int'(Apos),       (m_a < 128) ? 1 : 0);
      chk("MeminstOut", int'(MeminstOut), ad);
      if (m_memv[ad]) chk("RAMout", int'(RAMout), m_mem[ad]);
    end
  end

  // Literal expectation checked against both the DUT and the model.
  task automatic pin(input string name, input int dv, input int mv, input int exp);
    chk({name, "_dut"},   dv, exp);
    chk({name, "_model"}, mv, exp);
  endtask

  task automatic ctl(input logic irl, input logic jmp, input logic pcl, input logic mi,
                     input logic mw, input logic [1:0] as, input logic al, input logic sb,
                     input logic [7:0] iv);
    IRload = irl; JMPmux = jmp; PCload = pcl; Meminst = mi; MemWr = mw;
    Asel = as; Aload = al; Sub = sb; in = iv;
    @(negedge clk); #1;
  endtask

  initial begin
    clear = 0;
    IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MemWr = 0;
    Asel = 0; Aload = 0; Sub = 0; in = 0;
    for (int i = 0; i < 32; i++) begin m_mem[i] = 0; m_memv[i] = 0; end
    run = 1;
    repeat (2) @(negedge clk);
    #1;
    pin("rst_A",    int'(regAOut),    m_a, 0);
    pin("rst_Aeq0", int'(Aeq0),       (m_a == 0) ? 1 : 0, 1);
    pin("rst_Apos", int'(Apos),       (m_a < 128) ? 1 : 0, 1);
    pin("rst_addr", int'(MeminstOut), m_pc, 0);
    pin("rst_IR",   int'({IR75, IR40}), m_ir, 0);

    // Input then store at IR[4:0]=0.
    clear = 1;
    ctl(0,0,0,1,0,2'b01,1,0,8'd3);
    pin("in_A", int'(out), m_a, 3);
    ctl(0,0,0,1,1,2'b00,0,0,8'd0);
    pin("st_RAM", int'(RAMout), m_mem[0], 3);

    // Fetch with PC increment.
    ctl(1,0,1,0,0,2'b00,0,0,8'd0);
    pin("fe_IR40", int'(IR40), m_ir % 32, 3);
    pin("fe_IR75", int'(IR75), m_ir / 32, 0);
    pin("fe_PC",   int'(MeminstOut), m_pc, 1);

    // Clear pulse with a pending write and load: write must be dropped.
    ctl(0,0,0,1,0,2'b01,1,0,8'h77);
    MemWr = 1; Meminst = 1; Aload = 1; Asel = 2'b01; in = 8'h55; IRload = 1; PCload = 1;
    clear = 0;
    @(negedge clk); #1;
    clear = 1;
    ctl(0,0,0,1,0,2'b00,0,0,8'd0);
    pin("clr_RAM", int'(RAMout), m_mem[0], 3);
    pin("clr_A",   int'(out), m_a, 0);
    ctl(0,0,0,1,0,2'b10,1,0,8'd0);
    pin("ld_A", int'(out), m_a, 3);
    ctl(0,0,0,1,0,2'b00,1,0,8'd0);
    pin("add_A", int'(out), m_a, 6);

    // Subtract 3 - 5.
    ctl(0,0,0,1,0,2'b01,1,0,8'd5);
    ctl(0,0,0,1,1,2'b00,0,0,8'd0);
    ctl(0,0,0,1,0,2'b01,1,0,8'd3);
    ctl(0,0,0,1,0,2'b00,1,1,8'd0);
    pin("sub_A",    int'(out),  m_a, 8'hFE);
    pin("sub_Apos", int'(Apos), (m_a < 128) ? 1 : 0, 0);
    pin("sub_Aeq0", int'(Aeq0), (m_a == 0) ? 1 : 0, 0);

    // Jump to 31 then wrap to 0.
    ctl(0,0,0,1,0,2'b01,1,0,8'hBF);
    ctl(0,0,0,1,1,2'b00,0,0,8'd0);
    ctl(1,0,0,1,0,2'b00,0,0,8'd0);
    pin("jmp_IR75", int'(IR75), m_ir / 32, 5);
    ctl(0,1,1,0,0,2'b00,0,0,8'd0);
    pin("jmp_PC", int'(MeminstOut), m_pc, 31);
    ctl(0,0,1,0,0,2'b00,0,0,8'd0);
    pin("wrap_PC", int'(MeminstOut), m_pc, 0);

    // Fill every RAM word by stepping PC and storing the previous A.
    for (int i = 0; i < 32; i++)
      ctl(0,0,1,0,1,2'b01,1,0,8'($urandom));

    // Random control traffic with occasional clear pulses.
    for (int i = 0; i < 2000; i++) begin
      clear = ($urandom_range(0, 49) != 0);
      ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end
    clear = 1;
    ctl(0,0,0,0,0,2'b00,0,0,8'd0);
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
